// File: rtl/uart_tx_engine.sv
// uart_tx_engine: byte FIFO feeding an 8N1 serial shifter at a fixed baud rate.
// Bytes arrive on a valid/ready handshake, queue in a small circular buffer,
// and leave LSB first with one start and one stop bit per frame.
module uart_tx_engine #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       busy_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int BW = $clog2(SYMBOL_EDGE_TIME);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          push, pop;
  logic          fifo_nempty;

  // shifter state
  state_t        state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift_reg, shift_d;
  logic          ser_d;
  logic          sym_end;

  assign data_in_ready = (fifo_cnt != FULL_CNT);
  assign push          = data_in_valid && data_in_ready;
  assign fifo_nempty   = (fifo_cnt != '0);
  assign sym_end       = (baud_cnt == BAUD_LAST);
  assign busy_out      = (state != IDLE) || fifo_nempty;

  // FIFO data array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // shifter registers; serial line is registered so it never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_d;
      bit_idx    <= bit_d;
      shift_reg  <= shift_d;
      serial_out <= ser_d;
    end
  end

  // next-state: the line level for the coming symbol is chosen on the edge
  // that enters it, so each symbol lasts exactly SYMBOL_EDGE_TIME cycles
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift_reg;
    ser_d   = serial_out;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        ser_d = 1'b1;
        if (fifo_nempty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr];
          state_d = START;
          baud_d  = '0;
          ser_d   = 1'b0;
        end
      end
      START: begin
        if (sym_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          ser_d   = shift_reg[0];
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (sym_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            ser_d   = 1'b1;
          end else begin
            bit_d = bit_idx + 3'd1;
            ser_d = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (sym_end) begin
          baud_d = '0;
          // chain straight into the next frame when more bytes are queued
          if (fifo_nempty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr];
            state_d = START;
            ser_d   = 1'b0;
          end else begin
            state_d = IDLE;
            ser_d   = 1'b1;
          end
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: frame-level reference model plus a line decoder,
// a mid-symbol sample table for a single frame, and directed corner cases.
module tb_uart_tx_engine;

  localparam int CF    = 1000;
  localparam int BR    = 100;
  localparam int SYM   = CF / BR;
  localparam int FRAME = 10 * SYM;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid;
  logic       ready, serial_out, busy_out;

  uart_tx_engine #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(valid),
    .data_in_ready(ready), .serial_out(serial_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: a queue of waiting bytes and one frame in flight,
  // described by its byte and the cycles elapsed since its start edge
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_act;
  int         m_el;
  bit         m_last_push;
  logic [7:0] push_log[$];

  // line decoder: samples the middle of each symbol
  bit         rx_on;
  int         rx_t;
  logic [7:0] rx_b;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    int   off;
    logic ser;
    logic busy;
  } vec_t;
  vec_t vecs[19];

  logic sh[0:120];
  logic bh[0:120];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic m_ser();
    int s;
    if (!m_act) return 1'b1;
    s = m_el / SYM;
    if (s == 0) return 1'b0;
    if (s <= 8) return m_cur[s-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_act = 0;
    m_el = 0;
    m_cur = '0;
    m_last_push = 0;
    rx_on = 0;
    rx_t = 0;
  endtask

  // one clock: compare at negedge, advance model over the edge, return at edge+1
  task automatic step();
    bit p;
    int k;
    @(negedge clk);
    chk("serial", serial_out, m_ser());
    chk("ready", ready, (mq.size() != DEPTH));
    chk("busy", busy_out, (m_act || mq.size() != 0));
    if (rx_on) begin
      rx_t++;
      if (rx_t % SYM == SYM / 2) begin
        k = rx_t / SYM;
        if (k == 0) chk("rx_start", serial_out, 1'b0);
        else if (k <= 8) rx_b[k-1] = serial_out;
        else begin
          chk("rx_stop", serial_out, 1'b1);
          rx_q.push_back(rx_b);
          rx_on = 0;
        end
      end
    end else if (serial_out === 1'b0) begin
      rx_on = 1;
      rx_t = 0;
    end
    p = valid && (mq.size() != DEPTH);
    if (m_act) begin
      m_el++;
      if (m_el == FRAME) m_act = 0;
    end
    if (!m_act && mq.size() != 0) begin
      m_cur = mq.pop_front();
      m_act = 1;
      m_el = 0;
    end
    if (p) begin
      mq.push_back(data_in);
      push_log.push_back(data_in);
    end
    m_last_push = p;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 2000; k++) begin
      if (!m_act && mq.size() == 0) break;
      step();
    end
    chk("drain_bound", (k < 2000), 1);
    repeat (3) step();
  endtask

  task automatic chk_rx(input string nm);
    chk({nm, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({nm, "_byte"}, rx_q[i], exp_q[i]);
  endtask

  // push one byte with valid held until the model says it was taken
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    int w;
    data_in = b;
    valid = 1;
    acc_cyc = -1;
    for (w = 0; w < 400; w++) begin
      step();
      if (m_last_push) begin
        acc_cyc = cyc;
        break;
      end
    end
    chk("push_bound", (w < 400), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, ta, fell, tg;
    vecs = '{
      '{0, 1, 1}, '{1, 0, 1}, '{10, 0, 1}, '{11, 1, 1}, '{16, 1, 1},
      '{20, 1, 1}, '{21, 0, 1}, '{26, 0, 1}, '{36, 1, 1}, '{46, 0, 1},
      '{56, 1, 1}, '{66, 0, 1}, '{76, 1, 1}, '{86, 0, 1}, '{90, 0, 1},
      '{91, 1, 1}, '{96, 1, 1}, '{100, 1, 1}, '{101, 1, 0}
    };
    rst_n = 0;
    valid = 0;
    data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy_out, 1'b0);
    rst_n = 1;

    // idle stability
    repeat (1000) step();

    // single byte, mid-symbol samples from the table
    rx_q.delete();
    data_in = 8'h55;
    valid = 1;
    step();
    valid = 0;
    sh[0] = serial_out;
    bh[0] = busy_out;
    for (int k = 1; k <= 110; k++) begin
      step();
      sh[k] = serial_out;
      bh[k] = busy_out;
    end
    foreach (vecs[i]) begin
      chk($sformatf("single_ser_%0d", vecs[i].off), sh[vecs[i].off], vecs[i].ser);
      chk($sformatf("single_busy_%0d", vecs[i].off), bh[vecs[i].off], vecs[i].busy);
    end
    exp_q = {8'h55};
    chk_rx("single");

    // back-to-back frames
    rx_q.delete();
    data_in = 8'hA5;
    valid = 1;
    step();
    t0 = cyc;
    data_in = 8'h3C;
    step();
    valid = 0;
    fell = -1;
    for (int k = 0; k < 400 && fell < 0; k++) begin
      step();
      if (!busy_out) fell = cyc - t0;
    end
    chk("b2b_len", fell, 2 * FRAME + 1);
    repeat (3) step();
    exp_q = {8'hA5, 8'h3C};
    chk_rx("b2b");

    // fill the FIFO; sixth byte waits for the pop at the end of frame 1
    rx_q.delete();
    push_byte(8'h01, t0);
    for (int b = 2; b <= 6; b++) push_byte(8'(b), ta);
    valid = 0;
    chk("full_6th_accept", ta - t0, FRAME + 2);
    drain();
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_rx("full");

    // backpressure: junk toggles while full, only 0x77 is taken
    rx_q.delete();
    for (int b = 0; b < 5; b++) push_byte(8'h10 + 8'(b), ta);
    tg = 0;
    for (int w = 0; w < 400; w++) begin
      data_in = (mq.size() != DEPTH) ? 8'h77 : (tg != 0 ? 8'hFF : 8'h00);
      tg ^= 1;
      step();
      if (m_last_push) break;
    end
    valid = 0;
    drain();
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
    chk_rx("bp");

    // reset 45 cycles into a frame with two bytes queued
    rx_q.delete();
    push_byte(8'hC3, ta);
    push_byte(8'h81, ta);
    push_byte(8'h7E, ta);
    valid = 0;
    for (int w = 0; w < 200; w++) begin
      if (m_act && m_el == 45) break;
      step();
    end
    chk("mid_frame_reached", (m_act && m_el == 45), 1);
    chk("mid_queued", mq.size(), 2);
    #2 rst_n = 0;
    #1;
    chk("mrst_serial", serial_out, 1'b1);
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_busy", busy_out, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (300) step();
    chk("mrst_no_rx", rx_q.size(), 0);

    // randomized traffic against the model
    rx_q.delete();
    push_log.delete();
    for (int k = 0; k < 800; k++) begin
      valid = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      step();
    end
    valid = 0;
    drain();
    exp_q = push_log;
    chk_rx("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
